// File: rtl/lcd_frame_fetch_if.sv
// Frame-fetch bus bundle: LCD timing inputs, display FIFO status and SDRAM burst-read handshake.
// The master side is the fetch engine; the slave side is the timing generator, FIFO and arbiter.
interface lcd_frame_fetch_if;
    logic        lcd_framesync;
    logic        lcd_request;
    logic        fifo_empty;
    logic [10:0] fifo_usedw;
    logic        rd_ack;
    logic        rd_done;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [8:0]  rd_len;
    logic        fifo_clear;
    logic        frame_active;
    logic [15:0] underflow_cnt;

    modport master (
        input  lcd_framesync, lcd_request, fifo_empty, fifo_usedw, rd_ack, rd_done,
        output rd_req, rd_addr, rd_len, fifo_clear, frame_active, underflow_cnt
    );

    modport slave (
        output lcd_framesync, lcd_request, fifo_empty, fifo_usedw, rd_ack, rd_done,
        input  rd_req, rd_addr, rd_len, fifo_clear, frame_active, underflow_cnt
    );
endinterface

// File: rtl/lcd_frame_fetch.sv
// Fetches one frame per vsync as SDRAM bursts into the display FIFO; first rd_req CLR_CYC+2 cycles after vsync falls.
// Requests only when the FIFO has room for a full burst; rd_req holds until rd_ack and a started burst always completes.
module lcd_frame_fetch #(
    parameter int          H_DISP     = 640,
    parameter int          V_DISP     = 480,
    parameter int          BURST_LEN  = 64,
    parameter int          FIFO_DEPTH = 1024,
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int          CLR_CYC    = 4
) (
    input  logic               clk,
    input  logic               rst,
    lcd_frame_fetch_if.master  bus
);
    localparam logic [19:0] FRAME_WORDS = 20'(H_DISP * V_DISP);
    localparam logic [31:0] ROOM_THRESH = 32'(FIFO_DEPTH - BURST_LEN);
    localparam logic [8:0]  BURST_W     = 9'(BURST_LEN);
    localparam logic [3:0]  CLR_LAST    = 4'(CLR_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WAIT  = 3'd2,
        ST_REQ   = 3'd3,
        ST_BUSY  = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_sync_d;
    logic        r_pending;
    logic [3:0]  r_clr_cnt;
    logic [19:0] r_words_left;
    logic        r_rd_req;
    logic [23:0] r_rd_addr;
    logic [8:0]  r_rd_len;
    logic        r_fifo_clear;
    logic [15:0] r_uf_cnt;

    logic        w_frame_start;
    logic        w_room;
    logic [8:0]  w_burst_len;

    assign w_frame_start = r_sync_d & ~bus.lcd_framesync;
    assign w_room        = ({21'd0, bus.fifo_usedw} <= ROOM_THRESH);
    // Tail burst fits in 9 bits because it is never larger than BURST_LEN (<= 256).
    assign w_burst_len   = (r_words_left > 20'(BURST_LEN)) ? BURST_W : r_words_left[8:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sync_d     <= 1'b1;
            r_pending    <= 1'b0;
            r_clr_cnt    <= 4'd0;
            r_words_left <= 20'd0;
            r_rd_req     <= 1'b0;
            r_rd_addr    <= BASE_ADDR;
            r_rd_len     <= 9'd0;
            r_fifo_clear <= 1'b0;
            r_uf_cnt     <= 16'd0;
        end else begin
            r_sync_d <= bus.lcd_framesync;

            if (bus.lcd_request && bus.fifo_empty && (r_uf_cnt != 16'hFFFF)) begin
                r_uf_cnt <= r_uf_cnt + 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        r_state      <= ST_CLEAR;
                        r_fifo_clear <= 1'b1;
                        r_clr_cnt    <= 4'd0;
                    end
                end
                ST_CLEAR: begin
                    r_rd_addr    <= BASE_ADDR;
                    r_words_left <= FRAME_WORDS;
                    r_pending    <= 1'b0;
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state      <= ST_WAIT;
                        r_fifo_clear <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (w_frame_start) begin
                        r_state      <= ST_CLEAR;
                        r_fifo_clear <= 1'b1;
                        r_clr_cnt    <= 4'd0;
                    end else if ((r_words_left != 20'd0) && w_room) begin
                        r_state  <= ST_REQ;
                        r_rd_req <= 1'b1;
                        r_rd_len <= w_burst_len;
                    end
                end
                ST_REQ: begin
                    if (bus.rd_ack) begin
                        r_rd_addr    <= r_rd_addr + {15'd0, r_rd_len};
                        r_words_left <= r_words_left - {11'd0, r_rd_len};
                        r_rd_req     <= 1'b0;
                        r_state      <= ST_BUSY;
                        if (w_frame_start) begin
                            r_pending <= 1'b1;
                        end
                    end else if (w_frame_start) begin
                        r_rd_req     <= 1'b0;
                        r_state      <= ST_CLEAR;
                        r_fifo_clear <= 1'b1;
                        r_clr_cnt    <= 4'd0;
                    end
                end
                ST_BUSY: begin
                    // A vsync arriving on the rd_done cycle itself still counts as pending.
                    if (bus.rd_done) begin
                        if (r_pending || w_frame_start) begin
                            r_state      <= ST_CLEAR;
                            r_fifo_clear <= 1'b1;
                            r_clr_cnt    <= 4'd0;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (w_frame_start) begin
                        r_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_req        = r_rd_req;
    assign bus.rd_addr       = r_rd_addr;
    assign bus.rd_len        = r_rd_len;
    assign bus.fifo_clear    = r_fifo_clear;
    assign bus.frame_active  = (r_state != ST_IDLE) && (r_words_left != 20'd0);
    assign bus.underflow_cnt = r_uf_cnt;
endmodule

// File: tb/tb_lcd_frame_fetch.sv
// Bench for lcd_frame_fetch: full default frame with a randomized arbiter, plus directed edge cases.
module tb_lcd_frame_fetch;
    localparam int CLR_CYC     = 4;
    localparam int FRAME_WORDS = 640 * 480;
    localparam int BURST       = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_frame_fetch_if ifc ();
    lcd_frame_fetch_if sif ();

    lcd_frame_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    lcd_frame_fetch #(.H_DISP(100), .V_DISP(1), .BURST_LEN(64)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    bit          uf_rand  = 1'b0;
    logic [15:0] exp_uf   = 16'd0;
    logic [23:0] exp_addr;
    int          exp_left;
    int          exp_len;
    logic [23:0] last_addr;
    int          bursts;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: optionally randomize FIFO-side inputs, advance, update the underflow model.
    task automatic step();
        bit uf_now;
        if (uf_rand) begin
            ifc.lcd_request = 1'($urandom);
            ifc.fifo_empty  = 1'($urandom);
            ifc.fifo_usedw  = 11'($urandom_range(0, 960));
        end
        uf_now = ifc.lcd_request && ifc.fifo_empty;
        @(posedge clk);
        #1;
        if (rst) exp_uf = 16'd0;
        else if (uf_now && exp_uf != 16'hFFFF) exp_uf = exp_uf + 16'd1;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (ifc.rd_req !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk(tag, 64'(ifc.rd_req), 64'd1);
    endtask

    task automatic serve_burst();
        int d;
        wait_req("req_seen");
        exp_len = (exp_left > BURST) ? BURST : exp_left;
        chk("burst_addr", 64'(ifc.rd_addr), 64'(exp_addr));
        chk("burst_len", 64'(ifc.rd_len), 64'(exp_len));
        chk("active_pre", 64'(ifc.frame_active), 64'd1);
        last_addr = ifc.rd_addr;
        d = $urandom_range(0, 2);
        repeat (d) begin
            step();
            chk("req_hold", {30'd0, ifc.rd_req, ifc.rd_addr, ifc.rd_len},
                {30'd0, 1'b1, exp_addr, 9'(exp_len)});
        end
        ifc.rd_ack = 1'b1;
        step();
        ifc.rd_ack = 1'b0;
        exp_addr = exp_addr + 24'(exp_len);
        exp_left = exp_left - exp_len;
        chk("req_drop", 64'(ifc.rd_req), 64'd0);
        chk("active_post", 64'(ifc.frame_active), 64'(exp_left != 0));
        d = $urandom_range(0, 3);
        repeat (d) step();
        ifc.rd_done = 1'b1;
        step();
        ifc.rd_done = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;
        int clr_cnt;

        ifc.lcd_framesync = 1'b1;
        ifc.lcd_request   = 1'b0;
        ifc.fifo_empty    = 1'b0;
        ifc.fifo_usedw    = 11'd0;
        ifc.rd_ack        = 1'b0;
        ifc.rd_done       = 1'b0;
        sif.lcd_framesync = 1'b1;
        sif.lcd_request   = 1'b0;
        sif.fifo_empty    = 1'b0;
        sif.fifo_usedw    = 11'd0;
        sif.rd_ack        = 1'b0;
        sif.rd_done       = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_req", 64'(ifc.rd_req), 64'd0);
        chk("rst_addr", 64'(ifc.rd_addr), 64'd0);
        chk("rst_len", 64'(ifc.rd_len), 64'd0);
        chk("rst_clear", 64'(ifc.fifo_clear), 64'd0);
        chk("rst_active", 64'(ifc.frame_active), 64'd0);
        chk("rst_uf", 64'(ifc.underflow_cnt), 64'd0);
        rst = 1'b0;

        // Five underflow cycles
        ifc.lcd_request = 1'b1;
        ifc.fifo_empty  = 1'b1;
        repeat (5) step();
        ifc.lcd_request = 1'b0;
        ifc.fifo_empty  = 1'b0;
        chk("uf_five", 64'(ifc.underflow_cnt), 64'd5);

        // No request without a frame start
        cnt = 0;
        repeat (10) begin step(); cnt += int'(ifc.rd_req); end
        chk("idle_no_req", 64'(cnt), 64'd0);

        // Frame-start latency and clear pulse length
        ifc.lcd_framesync = 1'b0;
        n = 0;
        clr_cnt = 0;
        do begin
            step();
            n++;
            clr_cnt += int'(ifc.fifo_clear);
            if (n == 1) ifc.lcd_framesync = 1'b1;
        end while (ifc.rd_req !== 1'b1 && n < 30);
        chk("first_req_lat", 64'(n), 64'(CLR_CYC + 2));
        chk("clear_len", 64'(clr_cnt), 64'(CLR_CYC));

        // Full frame with randomized arbiter timing, FIFO level and underflow inputs
        uf_rand  = 1'b1;
        exp_addr = 24'h000000;
        exp_left = FRAME_WORDS;
        bursts   = 0;
        while (exp_left > 0 && bursts < 5000) begin
            serve_burst();
            bursts++;
        end
        chk("burst_count", 64'(bursts), 64'd4800);
        chk("last_addr", 64'(last_addr), 64'h04AFC0);
        chk("frame_active_end", 64'(ifc.frame_active), 64'd0);
        cnt = 0;
        repeat (10) begin step(); cnt += int'(ifc.rd_req); end
        chk("done_no_req", 64'(cnt), 64'd0);
        chk("uf_random", 64'(ifc.underflow_cnt), 64'(exp_uf));
        uf_rand = 1'b0;
        ifc.lcd_request = 1'b0;
        ifc.fifo_empty  = 1'b0;

        // FIFO room threshold
        ifc.fifo_usedw    = 11'd961;
        ifc.lcd_framesync = 1'b0;
        step();
        ifc.lcd_framesync = 1'b1;
        cnt = 0;
        repeat (15) begin step(); cnt += int'(ifc.rd_req); end
        chk("full_no_req", 64'(cnt), 64'd0);
        ifc.fifo_usedw = 11'd960;
        step();
        chk("room_req", 64'(ifc.rd_req), 64'd1);
        chk("room_addr", 64'(ifc.rd_addr), 64'd0);
        chk("room_len", 64'(ifc.rd_len), 64'd64);

        // Frame start while a burst is in flight
        ifc.rd_ack = 1'b1;
        step();
        ifc.rd_ack = 1'b0;
        chk("busy_addr", 64'(ifc.rd_addr), 64'd64);
        ifc.lcd_framesync = 1'b0;
        step();
        ifc.lcd_framesync = 1'b1;
        clr_cnt = int'(ifc.fifo_clear);
        repeat (3) begin step(); clr_cnt += int'(ifc.fifo_clear) + int'(ifc.rd_req); end
        chk("busy_no_clear", 64'(clr_cnt), 64'd0);
        ifc.rd_done = 1'b1;
        step();
        ifc.rd_done = 1'b0;
        chk("clear_after_done", 64'(ifc.fifo_clear), 64'd1);
        wait_req("pend_req");
        chk("pend_addr", 64'(ifc.rd_addr), 64'd0);

        // Reset while requesting
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_req_drop", 64'(ifc.rd_req), 64'd0);
        cnt = 0;
        repeat (20) begin step(); cnt += int'(ifc.rd_req); end
        chk("rst_no_req", 64'(cnt), 64'd0);
        chk("rst_inactive", 64'(ifc.frame_active), 64'd0);
        ifc.lcd_framesync = 1'b0;
        step();
        ifc.lcd_framesync = 1'b1;
        wait_req("rst_new_req");
        chk("rst_new_addr", 64'(ifc.rd_addr), 64'd0);

        // Short frame on the small instance: 64 + 36 words
        sif.lcd_framesync = 1'b0;
        step();
        sif.lcd_framesync = 1'b1;
        n = 0;
        while (sif.rd_req !== 1'b1 && n < 30) begin step(); n++; end
        chk("s_req1", 64'(sif.rd_req), 64'd1);
        chk("s_addr1", 64'(sif.rd_addr), 64'd0);
        chk("s_len1", 64'(sif.rd_len), 64'd64);
        sif.rd_ack = 1'b1; step(); sif.rd_ack = 1'b0;
        sif.rd_done = 1'b1; step(); sif.rd_done = 1'b0;
        n = 0;
        while (sif.rd_req !== 1'b1 && n < 30) begin step(); n++; end
        chk("s_req2", 64'(sif.rd_req), 64'd1);
        chk("s_addr2", 64'(sif.rd_addr), 64'd64);
        chk("s_len2", 64'(sif.rd_len), 64'd36);
        sif.rd_ack = 1'b1; step(); sif.rd_ack = 1'b0;
        chk("s_active_end", 64'(sif.frame_active), 64'd0);
        sif.rd_done = 1'b1; step(); sif.rd_done = 1'b0;
        cnt = 0;
        repeat (10) begin step(); cnt += int'(sif.rd_req); end
        chk("s_no_req", 64'(cnt), 64'd0);

        // Saturation of the underflow counter
        force dut.r_uf_cnt = 16'hFFFF;
        step();
        release dut.r_uf_cnt;
        ifc.lcd_request = 1'b1;
        ifc.fifo_empty  = 1'b1;
        repeat (3) step();
        ifc.lcd_request = 1'b0;
        ifc.fifo_empty  = 1'b0;
        chk("uf_saturate", 64'(ifc.underflow_cnt), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
